shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sin  input  1  serial data bit, sampled only when sin_en=1.
REQ-005 sin_en  input  1  bit strobe; one bit consumed per cycle with sin_en=1.
REQ-006 dir  input  1  0 = MSB-first (shift left, new bit into bit 0); 1 = LSB-first (shift right, new bit into bit WIDTH-1).
REQ-007 A  output  WIDTH  assembled parallel word (holding register).
REQ-008 A_valid  output  1  A holds an unread word.
REQ-009 A_ready  input  1  consumer accepts A when A_valid=1 and A_ready=1 in the same cycle.
REQ-010 busy  output  1  partial word in progress (FSM in RECV).
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 Internal shift register sreg[WIDTH-1:0], bit counter cnt (0..WIDTH-1), latched direction dir_q, FSM states IDLE and RECV.
REQ-013 IDLE: sin_en=1 -> shift sin into sreg per dir, latch dir_q=dir, cnt=1, go RECV; sin_en=0 -> stay, no state change.
REQ-014 RECV: sin_en=1 -> shift sin into sreg per dir_q, cnt+1; sin_en=0 -> hold sreg and cnt (gaps of any length allowed).
REQ-015 dir is sampled only on the first bit of a word; changes on dir during RECV have no effect until the next word.
REQ-016 Word completion: the edge consuming bit number WIDTH ends the word; cnt wraps to 0 and FSM returns to IDLE on that edge.
REQ-017 On completion, if A_valid=0, or A_valid=1 and A_ready=1 in that cycle: A loads the completed word and A_valid=1 after that edge (latency 1 cycle from last bit strobe).
REQ-018 On completion with A_valid=1 and A_ready=0: completed word discarded, A unchanged, overrun set to 1.
REQ-019 Handshake with no completion: A_valid=1 and A_ready=1 -> A_valid=0 after the edge; A holds last value.
REQ-020 A must not change while A_valid=1 and A_ready=0.
REQ-021 overrun is cleared only by reset.
REQ-022 busy = 1 exactly when FSM is in RECV.
REQ-023 For WIDTH-bit words, back-to-back streaming with sin_en held high and A_ready held high produces one word every WIDTH cycles with no loss.

Reset
REQ-024 reset=1 asynchronously forces: FSM=IDLE, cnt=0, sreg=0, dir_q=0, A=0, A_valid=0, busy=0, overrun=0.
REQ-025 Reset during RECV discards the partial word; first strobe after reset release starts a new word.
REQ-026 Outputs remain at reset values while reset=1 regardless of sin_en or A_ready.

Structure
REQ-027 Shared package holds: FSM state typedef (IDLE, RECV) and direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
REQ-028 One sub-module, shift_bit_counter: WIDTH-parameterised modulo-WIDTH counter with enable, async reset, and a terminal-count output used as the completion signal.
REQ-029 Counter width is $clog2(WIDTH); no other arithmetic in the block.

Verification (WIDTH=4)
REQ-030 MSB-first: dir=0, strobe bits 1,0,1,1 consecutively, A_ready=0 -> A=4'b1011, A_valid=1 one cycle after 4th strobe, overrun=0.
REQ-031 LSB-first: dir=1, strobe bits 1,0,1,1 -> A=4'b1101; dir toggled to 0 after first bit -> result still 4'b1101.
REQ-032 Overrun: send 4'b1011 then 4'b0110 (MSB-first), A_ready=0 -> A stays 4'b1011, overrun=1 after 8th strobe, stays 1 until reset.
REQ-033 Streaming: sin_en=1 and A_ready=1 continuously for 12 cycles with bits 1100_1010_0111 MSB-first -> A=4'hC,4'hA,4'h7 on successive valid cycles, overrun=0.
REQ-034 Gaps: bits 1,0,1,1 with 3 idle cycles between each strobe -> A=4'b1011, busy=1 from first strobe until the 4th.
REQ-035 Reset mid-word: 2 bits sent, reset pulsed asynchronously between edges -> all outputs 0 immediately; next 4 bits 0,1,1,0 MSB-first -> A=4'b0110.

Source files
------------

// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deserializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit counter; tc flags the strobe that consumes the last bit of a word.
module shift_bit_counter #(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     tc
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (tc)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/shift_deserializer.sv
// Serial bit stream to WIDTH-bit words with a one-entry holding register,
// valid/ready handoff and a sticky overrun flag for dropped words.
module shift_deserializer
   import shift_deserializer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             dir,
   output logic [WIDTH-1:0] A,
   output logic             A_valid,
   input  logic             A_ready,
   output logic             busy,
   output logic             overrun
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sreg, sreg_nxt;
   logic               dir_q, dir_eff;
   logic [$clog2(WIDTH)-1:0] cnt;
   logic               done;

   shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (sin_en),
      .cnt   (cnt),
      .tc    (done)
   );

   // Direction is taken live only on the first bit; afterwards the latched copy rules.
   assign dir_eff  = (state == IDLE) ? dir : dir_q;
   assign sreg_nxt = (dir_eff == DIR_LSB_FIRST) ? {sin, sreg[WIDTH-1:1]}
                                                : {sreg[WIDTH-2:0], sin};
   assign busy     = (state == RECV);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (sin_en) state_nxt = RECV;
         RECV: if (done)   state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg  <= '0;
         dir_q <= DIR_MSB_FIRST;
      end else if (sin_en) begin
         sreg <= sreg_nxt;
         if (state == IDLE) dir_q <= dir;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         A       <= '0;
         A_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (done) begin
         if (!A_valid || A_ready) begin
            A       <= sreg_nxt;
            A_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (A_valid && A_ready) begin
         A_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer at WIDTH=4.
module tb_shift_deserializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sin = 1'b0;
   logic       sin_en = 1'b0;
   logic       dir = 1'b0;
   logic [3:0] A;
   logic       A_valid;
   logic       A_ready = 1'b0;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_deserializer #(.WIDTH(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .sin     (sin),
      .sin_en  (sin_en),
      .dir     (dir),
      .A       (A),
      .A_valid (A_valid),
      .A_ready (A_ready),
      .busy    (busy),
      .overrun (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      sin_en = 1'b1;
      tick();
      sin_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sin_en = 1'b1;
      sin = 1'b1;
      A_ready = 1'b1;
      repeat (3) tick();
      checks++; if (A !== 4'h0) begin failures++; $display("FAIL reset_A got=%h exp=0", A); end
      checks++; if (A_valid !== 1'b0) begin failures++; $display("FAIL reset_A_valid got=%b exp=0", A_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      sin_en = 1'b0;
      sin = 1'b0;
      A_ready = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_msb_first();
      dir = 1'b0;
      A_ready = 1'b0;
      send_bit(1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL msb_busy got=%b exp=1", busy); end
      send_bit(1'b0);
      send_bit(1'b1);
      checks++; if (A_valid !== 1'b0) begin failures++; $display("FAIL msb_early_valid got=%b exp=0", A_valid); end
      send_bit(1'b1);
      checks++; if (A !== 4'b1011) begin failures++; $display("FAIL msb_A got=%b exp=1011", A); end
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", A_valid); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL msb_overrun got=%b exp=0", overrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL msb_busy_end got=%b exp=0", busy); end
      tick();
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL msb_hold_valid got=%b exp=1", A_valid); end
      A_ready = 1'b1;
      tick();
      A_ready = 1'b0;
      checks++; if (A_valid !== 1'b0) begin failures++; $display("FAIL msb_consume got=%b exp=0", A_valid); end
      checks++; if (A !== 4'b1011) begin failures++; $display("FAIL msb_A_hold got=%b exp=1011", A); end
   endtask

   task automatic test_lsb_first();
      dir = 1'b1;
      send_bit(1'b1);
      dir = 1'b0;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      checks++; if (A !== 4'b1101) begin failures++; $display("FAIL lsb_A got=%b exp=1101", A); end
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", A_valid); end
      A_ready = 1'b1;
      tick();
      A_ready = 1'b0;
   endtask

   task automatic test_overrun();
      logic [7:0] bits;
      dir = 1'b0;
      A_ready = 1'b0;
      bits = 8'b1011_0110;
      for (int i = 7; i >= 4; i--) send_bit(bits[i]);
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun); end
      for (int i = 3; i >= 0; i--) send_bit(bits[i]);
      checks++; if (A !== 4'b1011) begin failures++; $display("FAIL ovr_A got=%b exp=1011", A); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", A_valid); end
      A_ready = 1'b1;
      repeat (3) tick();
      A_ready = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
      #2 reset = 1'b1;
      #1;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [11:0] bits;
      logic [3:0]  got [3];
      int          n;
      bits = 12'b1100_1010_0111;
      n = 0;
      dir = 1'b0;
      A_ready = 1'b1;
      sin_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         sin = bits[i];
         tick();
         if (A_valid === 1'b1) begin
            if (n < 3) got[n] = A;
            n++;
         end
      end
      sin_en = 1'b0;
      checks++; if (n !== 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", n); end
      checks++; if (got[0] !== 4'hC) begin failures++; $display("FAIL stream_w0 got=%h exp=c", got[0]); end
      checks++; if (got[1] !== 4'hA) begin failures++; $display("FAIL stream_w1 got=%h exp=a", got[1]); end
      checks++; if (got[2] !== 4'h7) begin failures++; $display("FAIL stream_w2 got=%h exp=7", got[2]); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL stream_overrun got=%b exp=0", overrun); end
      tick();
      A_ready = 1'b0;
      checks++; if (A_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", A_valid); end
   endtask

   task automatic test_gaps();
      logic [3:0] bits;
      int         busy_bad;
      bits = 4'b1011;
      busy_bad = 0;
      dir = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         send_bit(bits[i]);
         if (i > 0) begin
            for (int g = 0; g < 3; g++) begin
               if (busy !== 1'b1) busy_bad++;
               tick();
            end
         end
      end
      checks++; if (busy_bad !== 0) begin failures++; $display("FAIL gap_busy got=%0d exp=0 low samples", busy_bad); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_busy_end got=%b exp=0", busy); end
      checks++; if (A !== 4'b1011) begin failures++; $display("FAIL gap_A got=%b exp=1011", A); end
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", A_valid); end
   endtask

   task automatic test_reset_mid_word();
      logic [3:0] bits;
      bits = 4'b0110;
      send_bit(1'b1);
      send_bit(1'b1);
      #2 reset = 1'b1;
      #1;
      checks++; if ({A, A_valid, busy, overrun} !== 7'b0) begin failures++; $display("FAIL rst_async got=%b exp=0000000", {A, A_valid, busy, overrun}); end
      sin_en = 1'b1;
      A_ready = 1'b1;
      tick();
      checks++; if ({A, A_valid, busy, overrun} !== 7'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0000000", {A, A_valid, busy, overrun}); end
      sin_en = 1'b0;
      A_ready = 1'b0;
      reset = 1'b0;
      tick();
      for (int i = 3; i >= 0; i--) send_bit(bits[i]);
      checks++; if (A !== 4'b0110) begin failures++; $display("FAIL rst_next_A got=%b exp=0110", A); end
      checks++; if (A_valid !== 1'b1) begin failures++; $display("FAIL rst_next_valid got=%b exp=1", A_valid); end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overrun();
      test_back_to_back();
      test_gaps();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
